// File: rtl/exu_gpr_arb.sv
// Round-robin arbiter granting one channel at a time ownership of the GPR
// read/write ports, with release on done and an optional hold-time watchdog.
module exu_gpr_arb #(
  parameter  int CHN_NUM  = 2,
  parameter  int MAX_HOLD = 16,
  localparam int OW       = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req      [CHN_NUM],
  input  logic          done     [CHN_NUM],
  output logic          chn_sels [CHN_NUM],
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic          timeout,
  output logic          dbg_state,
  output logic [OW-1:0] dbg_ptr
);

  // Handshake: req[i] is level-sensitive and held until chn_sels[i] rises;
  // done[i] is sampled only while chn_sels[i] is high, and the owner keeps
  // chn_sels through its done cycle so the last access completes.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam bit         WD_EN    = (MAX_HOLD > 0);
  localparam logic [7:0] HOLD_LIM = 8'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t               r_state;
  logic [CHN_NUM-1:0]   r_sel;
  logic [OW-1:0]        r_owner;
  logic [OW-1:0]        r_ptr;
  logic [7:0]           r_hold;
  logic                 r_timeout;

  state_t               w_state_nxt;
  logic [CHN_NUM-1:0]   w_sel_nxt;
  logic [OW-1:0]        w_owner_nxt;
  logic [OW-1:0]        w_ptr_nxt;
  logic [7:0]           w_hold_nxt;
  logic                 w_timeout_nxt;
  logic                 w_found;
  int                   w_win;
  logic                 w_done_own;
  logic                 w_wd_fire;

  function automatic int rr_idx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= CHN_NUM) s = s - CHN_NUM;
    return s;
  endfunction

  // Round-robin search starting at r_ptr; first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = 0;
    for (int k = 0; k < CHN_NUM; k++) begin
      for (int j = 0; j < CHN_NUM; j++) begin
        if (!w_found && (j == rr_idx(int'(r_ptr), k)) && req[j]) begin
          w_found = 1'b1;
          w_win   = j;
        end
      end
    end
  end

  always_comb begin
    w_done_own = 1'b0;
    for (int j = 0; j < CHN_NUM; j++) begin
      if (r_sel[j] && done[j]) w_done_own = 1'b1;
    end
    w_wd_fire = WD_EN && (r_state == S_BUSY) && (r_hold == HOLD_LIM) && !w_done_own;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BUSY;
          for (int j = 0; j < CHN_NUM; j++) w_sel_nxt[j] = (j == w_win);
          w_owner_nxt = OW'(w_win);
          w_ptr_nxt   = OW'((w_win + 1 == CHN_NUM) ? 0 : w_win + 1);
          w_hold_nxt  = 8'd0;
        end
      end
      S_BUSY: begin
        if (w_done_own || w_wd_fire) begin
          w_timeout_nxt = w_wd_fire;
          // r_ptr already points past the old owner, so it ranks last here.
          if (w_found) begin
            w_state_nxt = S_BUSY;
            for (int j = 0; j < CHN_NUM; j++) w_sel_nxt[j] = (j == w_win);
            w_owner_nxt = OW'(w_win);
            w_ptr_nxt   = OW'((w_win + 1 == CHN_NUM) ? 0 : w_win + 1);
            w_hold_nxt  = 8'd0;
          end else begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = '0;
            w_owner_nxt = '0;
          end
        end else begin
          w_hold_nxt = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
        w_owner_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  for (genvar g = 0; g < CHN_NUM; g++) begin : g_sel
    assign chn_sels[g] = r_sel[g];
  end

  assign busy      = (r_state == S_BUSY);
  assign owner     = r_owner;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_exu_gpr_arb.sv
// Directed bench for exu_gpr_arb (CHN_NUM=2, MAX_HOLD=4): grant latency,
// round-robin fairness, watchdog, coincidence, reset and stray done.
module tb_exu_gpr_arb;

  logic       clk;
  logic       rst;
  logic       req      [2];
  logic       done     [2];
  logic       chn_sels [2];
  logic       busy;
  logic [0:0] owner;
  logic       timeout;
  logic       dbg_state;
  logic [0:0] dbg_ptr;

  int         n_checks;
  int         n_errors;
  logic [0:0] exp_q[$];
  logic [0:0] exp_owner;

  exu_gpr_arb #(
    .CHN_NUM (2),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .chn_sels (chn_sels),
    .busy     (busy),
    .owner    (owner),
    .timeout  (timeout),
    .dbg_state(dbg_state),
    .dbg_ptr  (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r1, input logic r0);
    req[1] = r1;
    req[0] = r0;
  endtask

  task automatic set_done(input logic d1, input logic d0);
    done[1] = d1;
    done[0] = d0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sel_v();
    return {chn_sels[1], chn_sels[0]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    set_req(1'b0, 1'b0);
    set_done(1'b0, 1'b0);
    do_reset();
    chk("rst_sel", 32'(sel_v()), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_ptr", 32'(dbg_ptr), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

    // single request: grant cycle 1, done at cycle 3, idle at cycle 4
    set_req(1'b0, 1'b1);
    step();
    chk("single_sel_c1", 32'(sel_v()), 32'h1);
    chk("single_busy_c1", 32'(busy), 32'h1);
    chk("single_owner_c1", 32'(owner), 32'h0);
    set_req(1'b0, 1'b0);
    step();
    step();
    chk("single_sel_c3", 32'(sel_v()), 32'h1);
    set_done(1'b0, 1'b1);
    step();
    set_done(1'b0, 1'b0);
    chk("single_sel_c4", 32'(sel_v()), 32'h0);
    chk("single_busy_c4", 32'(busy), 32'h0);
    chk("single_ptr", 32'(dbg_ptr), 32'h1);

    // fairness after reset: grants 0,1,0,1 with no idle gap
    do_reset();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    set_req(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_owner = exp_q.pop_front();
      chk("fair_owner", 32'(owner), 32'(exp_owner));
      chk("fair_busy", 32'(busy), 32'h1);
      set_done(exp_owner == 1'b1, exp_owner == 1'b0);
      if (i == 3) set_req(1'b0, 1'b0);
    end
    step();
    set_done(1'b0, 1'b0);
    chk("fair_idle", 32'(busy), 32'h0);
    chk("fair_ptr", 32'(dbg_ptr), 32'h0);

    // watchdog: channel 1 holds cycles 1..4, forced release at cycle 5
    set_req(1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step();
      set_req(1'b0, 1'b0);
      chk("wd_sel_held", 32'(sel_v()), 32'h2);
      chk("wd_timeout_low", 32'(timeout), 32'h0);
    end
    step();
    chk("wd_sel_c5", 32'(sel_v()), 32'h0);
    chk("wd_timeout_c5", 32'(timeout), 32'h1);
    step();
    chk("wd_timeout_c6", 32'(timeout), 32'h0);

    // done on the 4th owned cycle wins over the watchdog
    set_req(1'b0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      set_req(1'b0, 1'b0);
    end
    chk("coin_sel_c4", 32'(sel_v()), 32'h1);
    set_done(1'b0, 1'b1);
    step();
    set_done(1'b0, 1'b0);
    chk("coin_sel_c5", 32'(sel_v()), 32'h0);
    chk("coin_timeout", 32'(timeout), 32'h0);
    chk("coin_ptr", 32'(dbg_ptr), 32'h1);

    // stray done: from non-owner while busy, then in idle
    set_req(1'b0, 1'b1);
    step();
    set_req(1'b0, 1'b0);
    chk("stray_owner", 32'(owner), 32'h0);
    set_done(1'b1, 1'b0);
    step();
    chk("stray_sel_busy", 32'(sel_v()), 32'h1);
    chk("stray_busy", 32'(busy), 32'h1);
    chk("stray_ptr_busy", 32'(dbg_ptr), 32'h1);
    set_done(1'b0, 1'b1);
    step();
    chk("stray_release", 32'(busy), 32'h0);
    step();
    set_done(1'b0, 1'b0);
    chk("stray_sel_idle", 32'(sel_v()), 32'h0);
    chk("stray_busy_idle", 32'(busy), 32'h0);
    chk("stray_ptr_idle", 32'(dbg_ptr), 32'h1);

    // reset mid-ownership, then channel 0 first
    set_req(1'b1, 1'b0);
    step();
    set_req(1'b0, 1'b0);
    chk("midrst_owner_pre", 32'(owner), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sel", 32'(sel_v()), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_owner", 32'(owner), 32'h0);
    chk("midrst_ptr", 32'(dbg_ptr), 32'h0);
    set_req(1'b1, 1'b1);
    step();
    chk("midrst_first", 32'(sel_v()), 32'h1);

    // sole requester re-granted back-to-back, then forced back-to-back handover
    set_req(1'b0, 1'b1);
    set_done(1'b0, 1'b1);
    step();
    set_done(1'b0, 1'b0);
    chk("regrant_owner", 32'(owner), 32'h0);
    chk("regrant_busy", 32'(busy), 32'h1);
    set_req(1'b1, 1'b0);
    step();
    chk("hold_owner_c5", 32'(owner), 32'h0);
    step();
    step();
    chk("hold_owner_c7", 32'(owner), 32'h0);
    step();
    chk("b2b_owner", 32'(owner), 32'h1);
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_timeout", 32'(timeout), 32'h1);
    set_req(1'b0, 1'b0);
    set_done(1'b1, 1'b0);
    step();
    set_done(1'b0, 1'b0);
    chk("b2b_idle", 32'(busy), 32'h0);
    chk("b2b_timeout_low", 32'(timeout), 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exu_gpr_arb.md
EXU_GPR_ARB -- requirements
Module: exu_gpr_arb

Interface
REQ-001 Parameter: CHN_NUM, default 2, number of requesting channels; legal range 1..8.
REQ-002 Parameter: MAX_HOLD, default 16, maximum cycles one channel may own the GPR ports; 0 disables the watchdog; legal range 0..255.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: req  input  1 x CHN_NUM (unpacked)  channel i requests ownership of the GPR read/write ports; held high until granted.
REQ-006 Port: done  input  1 x CHN_NUM (unpacked)  channel i signals its last GPR access is in the current cycle; it is ignored unless channel i is the owner.
REQ-007 Port: chn_sels  output  1 x CHN_NUM (unpacked)  registered one-hot owner select, or all-zero; it drives the select inputs of the GPR port mux.
REQ-008 Port: busy  output  1  high while any chn_sels bit is high.
REQ-009 Port: owner  output  OW = max(1, clog2(CHN_NUM))  index of the current owner; 0 when not busy.
REQ-010 Port: timeout  output  1  one-cycle pulse when the watchdog forces a release.

Function
REQ-011 The state machine SHALL have states IDLE (no owner) and BUSY (one owner), and every output SHALL be driven from registers.
REQ-012 Arbitration SHALL be round-robin: search from pointer ptr upward, modulo CHN_NUM, and the first channel with req high wins.
REQ-013 IDLE -> BUSY: at the edge where any req is high, the winner's chn_sels bit SHALL go high in the next cycle (1-cycle grant latency).
REQ-014 On every grant to channel i, ptr SHALL become (i+1) mod CHN_NUM.
REQ-015 In BUSY, chn_sels SHALL stay constant regardless of req changes on any channel.
REQ-016 Release SHALL occur at the edge where the owner's done is high: chn_sels stays asserted during the done cycle so the final write completes.
REQ-017 Back-to-back: if any req is high at the release edge, the state SHALL go directly to BUSY with the new winner, with no idle cycle.
REQ-018 In a back-to-back release the pointer was already advanced past the old owner, so the old owner has lowest priority; it is re-granted only if it is the sole requester.
REQ-019 If no req is high at the release edge, the state SHALL go to IDLE and chn_sels SHALL be all-zero next cycle.
REQ-020 A channel that drops req before being granted SHALL NOT be granted.
REQ-021 done from a non-owner, or done in IDLE, SHALL have no effect.
REQ-022 Watchdog, when MAX_HOLD > 0: hold_cnt SHALL clear on every grant and increment on each BUSY cycle.
REQ-023 If the owner is still present when hold_cnt = MAX_HOLD-1 without done, the watchdog SHALL force a release at that edge, i.e. the owner holds exactly MAX_HOLD cycles.
REQ-024 On a forced release, timeout SHALL pulse high for one cycle, coincident with the first cycle after release.
REQ-025 A forced release SHALL follow the same next-owner rules as a normal release (REQ-017..019).
REQ-026 If done and the watchdog limit coincide, the release SHALL be normal and timeout SHALL stay low.
REQ-027 hold_cnt width SHALL be 8 bits; it saturates and never wraps.
REQ-028 With CHN_NUM = 1, channel 0 SHALL be granted whenever it requests, and owner SHALL be constant 0.

Reset
REQ-029 When rst is high at an edge, the next cycle SHALL have: chn_sels all-zero, busy = 0, owner = 0, timeout = 0, ptr = 0, hold_cnt = 0, state IDLE.
REQ-030 Reset SHALL take priority over grant, release and watchdog, including reset asserted mid-ownership.
REQ-031 The first arbitration after reset deasserts SHALL start at channel 0.

Verification (CHN_NUM=2, MAX_HOLD=4 unless stated)
REQ-032 Single request: req[0]=1 at cycle 0 -> chn_sels={1,0}, busy=1, owner=0 from cycle 1; done[0] at cycle 3 -> chn_sels={0,0} at cycle 4.
REQ-033 Fairness: req[0]=req[1]=1 held continuously, each owner pulses done in its first owned cycle -> grants alternate 0,1,0,1 with no idle cycle between owners.
REQ-034 Watchdog: req[1]=1 at cycle 0, done never asserted -> chn_sels[1]=1 on cycles 1..4, chn_sels all-zero and timeout=1 on cycle 5, timeout=0 on cycle 6.
REQ-035 Coincidence: done[0] asserted on the 4th owned cycle -> normal release, timeout stays 0.
REQ-036 Reset mid-operation: channel 1 owns, rst=1 for one cycle -> all outputs 0 the next cycle; with req[0]=req[1]=1 afterwards, channel 0 is granted first.
REQ-037 Stray done: done[1]=1 while channel 0 owns, and done[0]=1 in IDLE -> no change to chn_sels, busy or ptr.
